// File: rtl/secondary_road_sensor_conditioner_if.sv
// Signal bundle between the secondary-road sensor conditioner and its
// environment: raw sensor and green-lamp status in, request/fault/wait-time out.
interface secondary_road_sensor_conditioner_if #(
  parameter int CNT_BITS = 16
);
  logic                sensorRaw;
  logic                secondaryGreenActive;
  logic                vehicleWaiting;
  logic                sensorFault;
  logic [CNT_BITS-1:0] waitCycles;

  // Environment side: drives the sensor and lamp status, observes the request.
  modport master (
    output sensorRaw,
    output secondaryGreenActive,
    input  vehicleWaiting,
    input  sensorFault,
    input  waitCycles
  );

  // Conditioner side.
  modport slave (
    input  sensorRaw,
    input  secondaryGreenActive,
    output vehicleWaiting,
    output sensorFault,
    output waitCycles
  );
endinterface

// File: rtl/secondary_road_sensor_conditioner.sv
// Secondary-road sensor conditioner: two-flop synchroniser, debounce, and a
// request FSM (IDLE/PENDING/SERVING) producing the registered vehicleWaiting
// request and a saturating wait-time counter.
// Optional macro SENSOR_STUCK_DETECT_EN adds a stuck-sensor detector and a
// fail-safe FAULT state (sensorFault=1, vehicleWaiting=1). Without it,
// sensorFault is tied to 0.
module secondary_road_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STUCK_CYCLES    = 1000,
  parameter int CNT_BITS        = 16
) (
  input logic clk,
  input logic reset_n,
  secondary_road_sensor_conditioner_if.slave bus
);

  localparam logic [CNT_BITS-1:0] DEB_LAST  = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONES  = {CNT_BITS{1'b1}};

  // Reject parameter sets that make the debounce or stuck detector meaningless.
  if (DEBOUNCE_CYCLES < 1 || STUCK_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("secondary_road_sensor_conditioner: invalid DEBOUNCE_CYCLES/STUCK_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
`ifdef SENSOR_STUCK_DETECT_EN
    , FAULT = 2'd3
`endif
  } state_e;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == CNT_ONES) ? v : v + {{(CNT_BITS-1){1'b0}}, 1'b1};
  endfunction

  logic                sync1_q, sync1_d;
  logic                sensor_sync_q, sensor_sync_d;
  logic                sensor_clean_q, sensor_clean_d;
  logic [CNT_BITS-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_BITS-1:0] wait_cycles_q, wait_cycles_d;
  logic                vehicle_waiting_q, vehicle_waiting_d;
  state_e              state_q, state_d;

`ifdef SENSOR_STUCK_DETECT_EN
  localparam logic [CNT_BITS-1:0] STUCK_LAST = CNT_BITS'(STUCK_CYCLES - 1);
  logic [CNT_BITS-1:0] stuck_cnt_q, stuck_cnt_d;
  logic                sensor_fault_q, sensor_fault_d;
  logic                stuck_hit_s;

  // Stuck counter: counts debounced-high cycles, saturating, cleared when low.
  always_comb begin
    stuck_cnt_d = {CNT_BITS{1'b0}};
    if (sensor_clean_q) begin
      stuck_cnt_d = sat_inc(stuck_cnt_q);
    end else begin
      stuck_cnt_d = {CNT_BITS{1'b0}};
    end
  end

  assign stuck_hit_s = sensor_clean_q && (stuck_cnt_q == STUCK_LAST);
`endif

  // Synchroniser and debounce: accept a level only after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    sync1_d        = bus.sensorRaw;
    sensor_sync_d  = sync1_q;
    sensor_clean_d = sensor_clean_q;
    deb_cnt_d      = {CNT_BITS{1'b0}};
    if (sensor_sync_q == sensor_clean_q) begin
      deb_cnt_d = {CNT_BITS{1'b0}};
    end else if (deb_cnt_q == DEB_LAST) begin
      sensor_clean_d = sensor_sync_q;
      deb_cnt_d      = {CNT_BITS{1'b0}};
    end else begin
      deb_cnt_d = deb_cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
    end
  end

  // Request FSM next state, wait counter, and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    wait_cycles_d = wait_cycles_q;
    case (state_q)
      IDLE: begin
        if (sensor_clean_q && !bus.secondaryGreenActive) begin
          state_d       = PENDING;
          wait_cycles_d = {CNT_BITS{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      PENDING: begin
        wait_cycles_d = sat_inc(wait_cycles_q);
        // Service wins over the vehicle leaving in the same cycle.
        if (bus.secondaryGreenActive) begin
          state_d = SERVING;
        end else if (!sensor_clean_q) begin
          state_d = IDLE;
        end else begin
          state_d = PENDING;
        end
      end
      SERVING: begin
        if (!bus.secondaryGreenActive) begin
          if (sensor_clean_q) begin
            state_d       = PENDING;
            wait_cycles_d = {CNT_BITS{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = SERVING;
        end
      end
`ifdef SENSOR_STUCK_DETECT_EN
      FAULT: begin
        if (!sensor_clean_q) begin
          state_d = IDLE;
        end else begin
          state_d = FAULT;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef SENSOR_STUCK_DETECT_EN
    // A stuck sensor overrides every other transition; wait time freezes.
    if (stuck_hit_s) begin
      state_d       = FAULT;
      wait_cycles_d = wait_cycles_q;
    end else begin
      state_d = state_d;
    end
    sensor_fault_d    = (state_d == FAULT);
    vehicle_waiting_d = (state_d == PENDING) || (state_d == FAULT);
`else
    vehicle_waiting_d = (state_d == PENDING);
`endif
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q           <= 1'b0;
      sensor_sync_q     <= 1'b0;
      sensor_clean_q    <= 1'b0;
      deb_cnt_q         <= {CNT_BITS{1'b0}};
      wait_cycles_q     <= {CNT_BITS{1'b0}};
      vehicle_waiting_q <= 1'b0;
      state_q           <= IDLE;
`ifdef SENSOR_STUCK_DETECT_EN
      stuck_cnt_q       <= {CNT_BITS{1'b0}};
      sensor_fault_q    <= 1'b0;
`endif
    end else begin
      sync1_q           <= sync1_d;
      sensor_sync_q     <= sensor_sync_d;
      sensor_clean_q    <= sensor_clean_d;
      deb_cnt_q         <= deb_cnt_d;
      wait_cycles_q     <= wait_cycles_d;
      vehicle_waiting_q <= vehicle_waiting_d;
      state_q           <= state_d;
`ifdef SENSOR_STUCK_DETECT_EN
      stuck_cnt_q       <= stuck_cnt_d;
      sensor_fault_q    <= sensor_fault_d;
`endif
    end
  end

  assign bus.vehicleWaiting = vehicle_waiting_q;
  assign bus.waitCycles     = wait_cycles_q;
`ifdef SENSOR_STUCK_DETECT_EN
  assign bus.sensorFault    = sensor_fault_q;
`else
  assign bus.sensorFault    = 1'b0;
`endif

endmodule
